// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry and capture-FSM state type for the write arbiter.
package fb_pkg;

  localparam int unsigned FB_DEPTH    = 307200;
  localparam int unsigned AW          = 19;
  localparam int unsigned DW          = 12;
  localparam int unsigned CAM_Q_DEPTH = 2;

  typedef enum logic [0:0] {
    StWaitSof = 1'b0,
    StActive  = 1'b1
  } cap_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count; data output is the head entry.
module sync_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];
  // Overflow/underflow requests are dropped rather than corrupting state.
  assign w_push  = i_push && !w_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= f_inc(r_wptr);
      if (w_pop)  r_rptr <= f_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/fb_wr_arbiter.sv
// Frame-buffer write arbiter: sequential camera capture into BRAM, with
// starvation-bounded random-access writes from the video-processing side.
module fb_wr_arbiter #(
  parameter int unsigned FB_DEPTH   = fb_pkg::FB_DEPTH,
  parameter int unsigned AW         = fb_pkg::AW,
  parameter int unsigned DW         = fb_pkg::DW,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_cam_valid,
  output logic          o_cam_ready,
  input  logic [DW-1:0] i_cam_data,
  input  logic          i_cam_sof,
  input  logic          i_vp_valid,
  output logic          o_vp_ready,
  input  logic [AW-1:0] i_vp_addr,
  input  logic [DW-1:0] i_vp_data,
  output logic          o_bram_we,
  output logic [AW-1:0] o_bram_addr,
  output logic [DW-1:0] o_bram_data,
  output logic          o_frame_done,
  output logic          o_frame_err,
  output logic          o_vp_addr_err
);

  import fb_pkg::*;

  localparam int unsigned QCW = $clog2(CAM_Q_DEPTH + 1);
  localparam int unsigned SW  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(FB_DEPTH - 1);
  localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(FB_DEPTH);

  logic          w_push;
  logic          w_q_empty;
  logic [QCW-1:0] w_q_count;
  logic          w_q_sof;
  logic [DW-1:0] w_q_data;
  logic          w_starved;
  logic          w_cam_grant;
  logic          w_vp_grant;
  logic          w_vp_in_range;

  cap_state_e    r_state;
  logic [AW-1:0] r_wr_addr;
  logic [SW-1:0] r_starve;

  sync_fifo #(
    .DEPTH (CAM_Q_DEPTH),
    .WIDTH (DW + 1)
  ) u_cam_q (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_push  (w_push),
    .i_data  ({i_cam_sof, i_cam_data}),
    .i_pop   (w_cam_grant),
    .o_data  ({w_q_sof, w_q_data}),
    .o_empty (w_q_empty),
    .o_count (w_q_count)
  );

  assign o_cam_ready   = (w_q_count < QCW'(CAM_Q_DEPTH));
  assign w_push        = i_cam_valid && o_cam_ready;
  assign w_starved     = (r_starve == SW'(STARVE_MAX)) && i_vp_valid;
  assign w_cam_grant   = !w_q_empty && !w_starved;
  assign w_vp_grant    = i_vp_valid && !w_cam_grant;
  assign o_vp_ready    = w_vp_grant;
  assign w_vp_in_range = ({1'b0, i_vp_addr} < DEPTH_EXT);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_starve <= '0;
    end else if (i_vp_valid && !w_vp_grant) begin
      if (r_starve != SW'(STARVE_MAX)) r_starve <= r_starve + SW'(1);
    end else begin
      r_starve <= '0;
    end
  end

  // Capture FSM and the registered BRAM port share one block so each cycle
  // issues at most one write from whichever side holds the grant.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state       <= StWaitSof;
      r_wr_addr     <= '0;
      o_bram_we     <= 1'b0;
      o_bram_addr   <= '0;
      o_bram_data   <= '0;
      o_frame_done  <= 1'b0;
      o_frame_err   <= 1'b0;
      o_vp_addr_err <= 1'b0;
    end else begin
      o_bram_we     <= 1'b0;
      o_frame_done  <= 1'b0;
      o_frame_err   <= 1'b0;
      o_vp_addr_err <= 1'b0;
      if (w_cam_grant) begin
        if (w_q_sof) begin
          o_bram_we   <= 1'b1;
          o_bram_addr <= '0;
          o_bram_data <= w_q_data;
          r_wr_addr   <= AW'(1);
          r_state     <= StActive;
          o_frame_err <= (r_state == StActive);
        end else if (r_state == StActive) begin
          o_bram_we   <= 1'b1;
          o_bram_addr <= r_wr_addr;
          o_bram_data <= w_q_data;
          if (r_wr_addr == LAST_ADDR) begin
            o_frame_done <= 1'b1;
            r_wr_addr    <= '0;
            r_state      <= StWaitSof;
          end else begin
            r_wr_addr <= r_wr_addr + AW'(1);
          end
        end
      end else if (w_vp_grant) begin
        if (w_vp_in_range) begin
          o_bram_we   <= 1'b1;
          o_bram_addr <= i_vp_addr;
          o_bram_data <= i_vp_data;
        end else begin
          o_vp_addr_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/fb_wr_arbiter.md
FB_WR_ARBITER -- requirements
Module: fb_wr_arbiter

Interface
REQ-001 SHALL have parameter FB_DEPTH, default 307200, frame buffer depth in pixels (640x480).
REQ-002 SHALL have parameter AW, default 19, BRAM address width.
REQ-003 SHALL have parameter DW, default 12, pixel width (RGB444).
REQ-004 SHALL have parameter STARVE_MAX, default 4, maximum consecutive cycles vp may wait while valid.
REQ-005 SHALL have port i_clk  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port i_rstn  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports i_cam_valid in 1, o_cam_ready out 1, i_cam_data in DW, i_cam_sof in 1: camera pixel stream; sof marks first pixel of a frame.
REQ-008 SHALL have ports i_vp_valid in 1, o_vp_ready out 1, i_vp_addr in AW, i_vp_data in DW: random-access writes from the video-processing requester.
REQ-009 SHALL have ports o_bram_we out 1, o_bram_addr out AW, o_bram_data out DW: registered BRAM write port.
REQ-010 SHALL have ports o_frame_done, o_frame_err, o_vp_addr_err: out, 1 bit each, single-cycle status pulses.

Function
REQ-011 SHALL transfer a beat on either stream only in a cycle where valid and ready are both 1.
REQ-012 SHALL buffer accepted cam beats in a 2-entry FIFO (cam_q); o_cam_ready = (cam_q count < 2), registered-free from i_cam_valid.
REQ-013 SHALL run a capture FSM with states WAIT_SOF and ACTIVE on cam beats leaving cam_q.
REQ-014 WAIT_SOF: beats with sof=0 are popped and discarded (no write); a beat with sof=1 is written at address 0, wr_addr<=1, goes to ACTIVE.
REQ-015 ACTIVE: each cam beat is written at wr_addr, then wr_addr increments.
REQ-016 SHALL, when the beat at address FB_DEPTH-1 is written, pulse o_frame_done with that write, set wr_addr<=0, return to WAIT_SOF.
REQ-017 SHALL, on sof=1 in ACTIVE, write that beat at address 0, set wr_addr<=1, stay ACTIVE, pulse o_frame_err.
REQ-018 Arbitration per cycle: cam (cam_q non-empty) wins unless starve_cnt == STARVE_MAX and i_vp_valid=1, in which case vp wins.
REQ-019 SHALL grant vp whenever cam_q is empty and i_vp_valid=1; o_vp_ready = vp grant (combinational).
REQ-020 starve_cnt SHALL increment (saturating at STARVE_MAX) when i_vp_valid=1 and vp not granted; clear on vp grant or i_vp_valid=0.
REQ-021 SHALL assert o_vp_ready for vp beats with i_vp_addr >= FB_DEPTH but not write them, pulsing o_vp_addr_err one cycle later.
REQ-022 Latency: granted beat appears on o_bram_* exactly 1 cycle after grant; o_bram_we=0 in cycles with no write.
REQ-023 SHALL never issue two writes in one cycle; cam discards in WAIT_SOF consume a cam grant slot.
REQ-024 Simultaneous cam push and pop on a full FIFO SHALL NOT occur (ready=0 when full); push+pop when count=1 leaves count=1.

Reset
REQ-025 On i_rstn=0 SHALL asynchronously force: FSM=WAIT_SOF, wr_addr=0, cam_q empty, starve_cnt=0, o_bram_we=0, o_bram_addr=0, o_bram_data=0, all status pulses 0.
REQ-026 o_cam_ready SHALL be 1 and o_vp_ready 0 during reset-deasserted idle; reset mid-frame discards cam_q contents and the partial frame.

Structure
REQ-027 FB_DEPTH, AW, DW and the capture-state enum SHALL live in shared package fb_pkg.
REQ-028 cam_q SHALL be sub-module sync_fifo (parameterised depth/width, count output).

Verification
REQ-029 Reset, then 5 cam beats without sof -> o_bram_we stays 0, wr_addr=0.
REQ-030 sof beat 0x0AB then 307199 beats -> writes at 0..307199, o_frame_done pulses once with addr 307199, FSM back to WAIT_SOF.
REQ-031 cam valid continuously plus vp valid at addr 0x100 -> vp granted within STARVE_MAX+1 cycles, no cam beat lost.
REQ-032 vp write addr 307200 data 0xFFF -> o_vp_ready=1, no BRAM write, o_vp_addr_err pulse next cycle.
REQ-033 sof at wr_addr 1000 -> write at addr 0, o_frame_err pulse, next beat at addr 1.
REQ-034 i_rstn low mid-frame with cam_q full -> outputs zero immediately; after release, first write only after next sof.
